uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised, oversampling UART receiver for the host-to-FPGA image/command link. It has a configurable data width, optional parity and 1 or 2 stop bits. It synchronises and mid-bit samples the serial line, rejects false starts, and flags parity, framing and overrun errors. Received words go to downstream buffering (pixel loader, command decoder) over a valid/ready handshake.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 4 or more.
DATA_BITS, 8, data bits per frame; legal range 5 to 9; sent LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
SYNC_STAGES, 2, flops in the rx_in synchroniser; 2 or more.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset; synchronous and active-low (rst = 0 resets on the next clk edge)
rx_in  in  1  asynchronous serial line; idles high
rx_data  out  DATA_BITS  received word
rx_valid  out  1  rx_data and the error flags hold a word
rx_ready  in  1  consumer accepts the word
parity_err  out  1  parity mismatch on the held word (0 when PARITY = 0)
frame_err  out  1  a stop bit sampled 0 on the held word
overrun  out  1  one-cycle pulse: a completed frame was dropped
busy  out  1  receiver is inside a frame (state is not IDLE)

Behaviour:
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
- Reset also sets state to IDLE, clears counters and presets all synchroniser flops to 1.
- Reset mid-frame abandons the frame; no output is produced for it.
- Synchroniser: rx_in passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s. A previous-value flop provides falling-edge detection.
- Bit counter: cyc_cnt has width $clog2(CLKS_PER_BIT). The mid-bit point is cyc_cnt = CLKS_PER_BIT/2 - 1 (integer division).
- State IDLE: a falling edge on rx_s (previous = 1, current = 0) in cycle t0 moves to START with cyc_cnt = 0.
- State START: at the mid point, sample rx_s.
  - If rx_s = 1, it is a false start; return to IDLE with no output.
  - If rx_s = 0, go to DATA.
- Sampling schedule: from START on, each sample is exactly CLKS_PER_BIT cycles after the previous one. Start mid-sample is at t0 + CLKS_PER_BIT/2; bit k is sampled at t0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
- State DATA: shift in DATA_BITS samples, LSB first. Then go to PAR if PARITY != 0, else to STOP.
- State PAR: one sample. Odd parity requires XOR(data, parity bit) = 1; even parity requires it = 0. Store the mismatch.
- State STOP: STOP_BITS samples. Any 0 sample sets the frame error.
- Completion is the cycle of the last stop mid-sample. On the next edge:
  - Go to IDLE, or to BREAK if the final stop sample was 0.
  - Deliver the word per the handshake rules below.
- State BREAK: wait until rx_s = 1, then go to IDLE. A line held low therefore produces one frame_err word, not a stream.
- Re-arm: returning to IDLE at the stop-bit midpoint allows back-to-back frames with no idle gap.
- Handshake:
  - A transfer occurs on any edge where rx_valid = 1 and rx_ready = 1.
  - On delivery, set rx_valid = 1 and load rx_data, parity_err and frame_err together.
  - rx_data and the flags stay stable while rx_valid = 1.
  - rx_valid falls on the edge after a transfer, unless a new frame delivers on that same edge.
- Completion with rx_valid = 0, or with rx_valid = 1 and rx_ready = 1 in the same cycle: load the new word; rx_valid = 1.
- Completion with rx_valid = 1 and rx_ready = 0: drop the new word, keep the held word, and pulse overrun high for exactly one cycle.
- A word with a framing error is still delivered, with frame_err = 1.
- Latency: rx_valid rises SYNC_STAGES + 1 cycles after the last stop mid-point on the raw rx_in timeline.

Test Plan:
- CLKS_PER_BIT = 16, 8N1, send 0xA5 then 0x3C back-to-back with rx_ready = 1 -> two rx_valid pulses carrying 0xA5 and 0x3C; all error flags 0; overrun never asserted.
- rx_in low for 4 cycles then high -> START aborts at its mid-sample; busy returns to 0; rx_valid stays 0.
- PARITY = 2 (even), send 0x3C with parity bit 1 -> rx_data = 0x3C, parity_err = 1. Resend with parity bit 0 -> parity_err = 0.
- Send 0x55 with stop bit 0, line held low for 40 cycles, then idle -> one word 0x55 with frame_err = 1. No further frames until the line goes high; the next valid frame is received correctly.
- rx_ready = 0, send 0x11 then 0x22 -> held rx_data = 0x11; overrun high for exactly 1 cycle at 0x22 completion. Raise rx_ready -> rx_valid drops the next cycle.
- Assert rst = 0 for 1 cycle midway through the data bits of 0x81 -> all outputs return to reset values. The following frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with parity, 1/2 stop bits, false-start rejection,
// break handling and a valid/ready output holding register.
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronised line
//   START | checking the start bit at its midpoint
//   DATA  | shifting in data bits, LSB first
//   PAR   | sampling the parity bit
//   STOP  | sampling the stop bit(s)
//   BRK   | line held low after a framing error; wait for it to go high
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   rx_p;
    state_t                 state;
    logic [CW-1:0]          cyc_cnt;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_fail;
    logic                   stop_fail;
    logic                   tick;

    assign rx_s = sync[SYNC_STAGES-1];
    assign tick = (cyc_cnt == LAST);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync       <= '1;
            rx_p       <= 1'b1;
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_fail   <= 1'b0;
            stop_fail  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], rx_in};
            rx_p    <= rx_s;
            overrun <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_p && !rx_s) begin
                        state   <= START;
                        cyc_cnt <= '0;
                    end
                end
                START: begin
                    if (cyc_cnt == MID) begin
                        cyc_cnt   <= '0;
                        bit_cnt   <= '0;
                        par_fail  <= 1'b0;
                        stop_fail <= 1'b0;
                        state     <= rx_s ? IDLE : DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        cyc_cnt <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                PAR: begin
                    if (tick) begin
                        cyc_cnt  <= '0;
                        par_fail <= (PARITY == 1) ? !(^shreg ^ rx_s) : (^shreg ^ rx_s);
                        state    <= STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == 4'(STOP_BITS - 1)) begin
                            // Final stop midpoint: hand the word over and re-arm.
                            if (!rx_valid || rx_ready) begin
                                rx_data    <= shreg;
                                parity_err <= par_fail;
                                frame_err  <= stop_fail | !rx_s;
                                rx_valid   <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            bit_cnt <= '0;
                            state   <= rx_s ? IDLE : BRK;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            stop_fail <= stop_fail | !rx_s;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                BRK: begin
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
